change_dispenser: RTL
=====================

// Module: change_dispenser
// PURPOSE
//   Money-out side of the vending machine; the counterpart of the coin-value input path.
//   Takes a change amount from the controller over a valid/ready handshake.
//   Pays it out one coin at a time to the coin hopper, largest denomination first.
//   Tracks per-denomination coin inventory and reports any amount it could not pay.
// PARAMETERS
//   AMT_W      8  width of change amount / remaining / short_amount
//   CNT_W      4  width of each inventory counter
//   INIT_COUNT 2  coins per denomination after reset or refill
// PORTS
//   clock         in   1      system clock, rising edge
//   reset_n       in   1      asynchronous, active-low reset
//   req_valid     in   1      change request valid
//   req_amount    in   AMT_W  change to pay, in coin units
//   req_ready     out  1      dispenser can accept a request
//   coin_valid    out  1      coin offered to hopper
//   coin_value    out  4      denomination offered (5, 2 or 1)
//   coin_ready    in   1      hopper takes the coin this cycle
//   done          out  1      one-cycle pulse: request finished
//   short_amount  out  AMT_W  unpaid remainder; held from done until next accept
//   refill        in   1      reload all inventories to INIT_COUNT
//   inv_big/inv_mid/inv_small  out  CNT_W  current coin inventory per denomination
// BEHAVIOUR
//   Reset (async, reset_n=0):
//     state=IDLE, req_ready=1, coin_valid=0, coin_value=0, done=0, short_amount=0.
//     All inventories = INIT_COUNT.
//   FSM states: IDLE -> SELECT -> OFFER -> SELECT ... -> FINISH -> IDLE.
//   IDLE:
//     req_ready = !refill.
//     refill=1: reloads inventories; no request is accepted that cycle.
//     req_valid && req_ready: latch remaining=req_amount, clear short_amount, go to SELECT.
//   SELECT (1 cycle):
//     Pick the largest coin with value<=remaining and inventory>0 (5, then 2, then 1).
//     Coin found: load coin_value, go to OFFER. No coin: go to FINISH.
//     remaining==0 always goes to FINISH.
//   OFFER:
//     coin_valid=1; coin_value is held stable until coin_ready.
//     coin_valid && coin_ready: remaining -= value, that inventory decrements, go to SELECT.
//     coin_ready low: stay in OFFER, outputs unchanged.
//   FINISH: done=1 for one cycle, short_amount=remaining, go to IDLE.
//   Latency: accept at cycle N -> first coin_valid at N+2. Each coin takes >= 2 cycles.
//   Inventory never underflows, because selection requires inventory>0.
//   refill is ignored outside IDLE.
//   Arithmetic: remaining is AMT_W bits wide; subtraction never wraps because value<=remaining.
//   A reset mid-request abandons the request: no done pulse, inventories return to INIT_COUNT.
// CONFIGURATION
//   CHANGE_AUDIT_EN defined:
//     Adds output audit_total[15:0], reset to 0.
//     Increments by coin_value on every accepted coin; wraps modulo 2^16.
//     Not cleared by refill.
//   CHANGE_AUDIT_EN undefined: no port, no counter.
// STRUCTURE
//   vend_pkg holds:
//     coin denominations COIN_BIG=5, COIN_MID=2, COIN_SMALL=1
//     the FSM state enum
//     coin_value width (4)
//   Sub-module coin_select: combinational priority picker.
//     Inputs: remaining and the three inventories.
//     Outputs: found and coin value.
// TESTING
//   1. Reset, then req 15 with coin_ready=1 -> coins 5,5,2,2,1; done with short_amount=0;
//      inventories 0/0/1.
//   2. Continue from 1 without refill, req 9 -> one coin 1; done with short_amount=8;
//      inventories 0/0/0.
//   3. refill, then req 7 with coin_ready low for 3 cycles on the first coin ->
//      coin_value=5 held for 3 cycles, then 5,2; short_amount=0.
//   4. req_amount=0 -> no coin_valid; done 2 cycles after accept; short_amount=0.
//   5. refill and req_valid in the same cycle -> req_ready=0 that cycle; request accepted next cycle.
//      reset_n low during OFFER -> all outputs at reset values immediately, no done.
//   6. CHANGE_AUDIT_EN: after scenario 1, audit_total=15; after scenario 2, audit_total=16.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared constants and types for the vending machine money-out path.
package vend_pkg;

   localparam int COIN_W = 4;

   localparam logic [COIN_W-1:0] COIN_BIG   = 4'd5;
   localparam logic [COIN_W-1:0] COIN_MID   = 4'd2;
   localparam logic [COIN_W-1:0] COIN_SMALL = 4'd1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SELECT,
      ST_OFFER,
      ST_FINISH
   } disp_state_t;

endpackage

// File: rtl/coin_select.sv
// Combinational priority picker: largest denomination that fits the
// remaining amount and still has stock.
module coin_select
   import vend_pkg::*;
#(
   parameter int AMT_W = 8,
   parameter int CNT_W = 4
) (
   input  logic [AMT_W-1:0]  i_remaining,
   input  logic [CNT_W-1:0]  i_inv_big,
   input  logic [CNT_W-1:0]  i_inv_mid,
   input  logic [CNT_W-1:0]  i_inv_small,
   output logic              o_found,
   output logic [COIN_W-1:0] o_value
);

   logic w_big_ok;
   logic w_mid_ok;
   logic w_small_ok;

   assign w_big_ok   = (i_remaining >= AMT_W'(COIN_BIG))
                       && (i_inv_big != '0);
   assign w_mid_ok   = (i_remaining >= AMT_W'(COIN_MID))
                       && (i_inv_mid != '0);
   assign w_small_ok = (i_remaining >= AMT_W'(COIN_SMALL))
                       && (i_inv_small != '0);

   always_comb begin
      o_found = 1'b1;
      o_value = '0;
      priority case (1'b1)
         w_big_ok:   o_value = COIN_BIG;
         w_mid_ok:   o_value = COIN_MID;
         w_small_ok: o_value = COIN_SMALL;
         default:    o_found = 1'b0;
      endcase
   end

endmodule

// File: rtl/change_dispenser.sv
// Pays change one coin at a time, largest first, tracking inventory.
// Optional CHANGE_AUDIT_EN adds a running total of dispensed value.
module change_dispenser
   import vend_pkg::*;
#(
   parameter int AMT_W      = 8,
   parameter int CNT_W      = 4,
   parameter int INIT_COUNT = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   input  logic [AMT_W-1:0]  req_amount,
   output logic              req_ready,
   output logic              coin_valid,
   output logic [COIN_W-1:0] coin_value,
   input  logic              coin_ready,
   output logic              done,
   output logic [AMT_W-1:0]  short_amount,
   input  logic              refill,
   output logic [CNT_W-1:0]  inv_big,
   output logic [CNT_W-1:0]  inv_mid,
   output logic [CNT_W-1:0]  inv_small
`ifdef CHANGE_AUDIT_EN
   ,
   output logic [15:0]       audit_total
`endif
);

   localparam logic [CNT_W-1:0] INIT_INV = CNT_W'(INIT_COUNT);

   disp_state_t        r_state;
   logic [AMT_W-1:0]   r_remaining;
   logic               r_coin_valid;
   logic [COIN_W-1:0]  r_coin_value;
   logic               r_done;
   logic [AMT_W-1:0]   r_short;
   logic [CNT_W-1:0]   r_inv_big;
   logic [CNT_W-1:0]   r_inv_mid;
   logic [CNT_W-1:0]   r_inv_small;
   logic               w_found;
   logic [COIN_W-1:0]  w_value;
`ifdef CHANGE_AUDIT_EN
   logic [15:0]        r_audit;
`endif

   coin_select #(
      .AMT_W (AMT_W),
      .CNT_W (CNT_W)
   ) u_sel (
      .i_remaining (r_remaining),
      .i_inv_big   (r_inv_big),
      .i_inv_mid   (r_inv_mid),
      .i_inv_small (r_inv_small),
      .o_found     (w_found),
      .o_value     (w_value)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_remaining  <= '0;
         r_coin_valid <= 1'b0;
         r_coin_value <= '0;
         r_done       <= 1'b0;
         r_short      <= '0;
         r_inv_big    <= INIT_INV;
         r_inv_mid    <= INIT_INV;
         r_inv_small  <= INIT_INV;
`ifdef CHANGE_AUDIT_EN
         r_audit      <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               // refill wins; the request waits a cycle
               if (refill) begin
                  r_inv_big   <= INIT_INV;
                  r_inv_mid   <= INIT_INV;
                  r_inv_small <= INIT_INV;
               end else if (req_valid) begin
                  r_remaining <= req_amount;
                  r_short     <= '0;
                  r_state     <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               if (w_found) begin
                  r_coin_value <= w_value;
                  r_coin_valid <= 1'b1;
                  r_state      <= ST_OFFER;
               end else begin
                  r_done  <= 1'b1;
                  r_short <= r_remaining;
                  r_state <= ST_FINISH;
               end
            end
            ST_OFFER: begin
               if (coin_ready) begin
                  r_remaining  <= r_remaining
                                  - AMT_W'(r_coin_value);
                  r_coin_valid <= 1'b0;
                  r_coin_value <= '0;
                  r_state      <= ST_SELECT;
                  if (r_coin_value == COIN_BIG)
                     r_inv_big <= r_inv_big - CNT_W'(1);
                  else if (r_coin_value == COIN_MID)
                     r_inv_mid <= r_inv_mid - CNT_W'(1);
                  else
                     r_inv_small <= r_inv_small - CNT_W'(1);
`ifdef CHANGE_AUDIT_EN
                  r_audit <= r_audit + 16'(r_coin_value);
`endif
               end
            end
            ST_FINISH: r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready    = (r_state == ST_IDLE) && !refill;
   assign coin_valid   = r_coin_valid;
   assign coin_value   = r_coin_value;
   assign done         = r_done;
   assign short_amount = r_short;
   assign inv_big      = r_inv_big;
   assign inv_mid      = r_inv_mid;
   assign inv_small    = r_inv_small;
`ifdef CHANGE_AUDIT_EN
   assign audit_total  = r_audit;
`endif

endmodule
